// File: rtl/ram_pkg.sv
// Shared types and constants for the DRAM sequencer and its cycle timer.
package ram_pkg;

    // Width of the per-state cycle counter
    localparam int CNT_W = 3;

    // Default DRAM timing, in FCLK cycles
    localparam int TCAS_DEF     = 1;
    localparam int TRP_DEF      = 2;
    localparam int TRAS_REF_DEF = 3;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        COL,
        HOLD,
        PRE,
        REFCAS,
        REFRAS
    } ramState_t;

    // Counter load value for a state lasting 'cycles' cycles (counts down to 0)
    function automatic logic [CNT_W-1:0] cycLoad(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/ram_cyc_timer.sv
// Loadable 3-bit down-counter timing the COL, REFRAS and PRE states.
// Saturates at zero; done is high while the count is zero.
module ram_cyc_timer
    import ram_pkg::*;
(
    input  logic             FCLK,
    input  logic             nRESET,
    input  logic             load,
    input  logic [CNT_W-1:0] loadValue,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Load on state entry, otherwise count down and hold at zero
    always_ff @(posedge FCLK or negedge nRESET) begin
        if (!nRESET) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/ram_sequencer.sv
// DRAM sequencer: arbitrates CPU accesses against CAS-before-RAS refresh and
// drives nRAS/nCAS, the row/column select, RAMReady and RefAck.
// Optional feature: define RAMSEQ_URGENT_PREEMPT_EN to let RefUrgent beat a
// simultaneous CPU request in IDLE; otherwise RefUrgent is ignored.
module ram_sequencer
    import ram_pkg::*;
#(
    parameter int TCAS     = TCAS_DEF,
    parameter int TRP      = TRP_DEF,
    parameter int TRAS_REF = TRAS_REF_DEF
) (
    input  logic FCLK,
    input  logic nRESET,
    input  logic ASActive,
    input  logic ASInactive,
    input  logic RAMCS,
    input  logic RefReq,
    input  logic RefUrgent,
    output logic RefAck,
    output logic RAMReady,
    output logic nRAS,
    output logic nCAS,
    output logic RASel
);

    ramState_t        stateReg;
    ramState_t        stateNext;
    logic             nRasNext;
    logic             nCasNext;
    logic             raSelNext;
    logic             readyNext;
    logic             refAckNext;
    logic             enterPre;
    logic             timerLoad;
    logic [CNT_W-1:0] timerValue;
    logic             timerDone;
    logic             urgentHit;

`ifdef RAMSEQ_URGENT_PREEMPT_EN
    assign urgentHit = RefUrgent;
`else
    logic unusedRefUrgent;
    assign urgentHit       = 1'b0;
    assign unusedRefUrgent = RefUrgent;
`endif

    ram_cyc_timer uTimer (
        .FCLK      (FCLK),
        .nRESET    (nRESET),
        .load      (timerLoad),
        .loadValue (timerValue),
        .done      (timerDone)
    );

    // Next state and next registered outputs; outputs hold unless a transition changes them
    always_comb begin
        stateNext  = stateReg;
        nRasNext   = nRAS;
        nCasNext   = nCAS;
        raSelNext  = RASel;
        readyNext  = RAMReady;
        refAckNext = 1'b0;
        enterPre   = 1'b0;
        timerLoad  = 1'b0;
        timerValue = '0;

        case (stateReg)
            IDLE: begin
                if (urgentHit) begin
                    stateNext = REFCAS;
                    nCasNext  = 1'b0;
                end else if (ASActive && RAMCS) begin
                    stateNext = ROW;
                    nRasNext  = 1'b0;
                end else if (RefReq) begin
                    stateNext = REFCAS;
                    nCasNext  = 1'b0;
                end
            end
            ROW: begin
                if (ASInactive) begin
                    enterPre = 1'b1;
                end else begin
                    stateNext  = COL;
                    nCasNext   = 1'b0;
                    raSelNext  = 1'b1;
                    timerLoad  = 1'b1;
                    timerValue = cycLoad(TCAS);
                end
            end
            COL: begin
                // An abort wins over a coincident end of the CAS period
                if (ASInactive) begin
                    enterPre = 1'b1;
                end else if (timerDone) begin
                    stateNext = HOLD;
                    readyNext = 1'b1;
                end
            end
            HOLD: begin
                if (ASInactive) begin
                    enterPre = 1'b1;
                end
            end
            PRE: begin
                if (timerDone) begin
                    stateNext = IDLE;
                end
            end
            REFCAS: begin
                stateNext  = REFRAS;
                nRasNext   = 1'b0;
                refAckNext = 1'b1;
                timerLoad  = 1'b1;
                timerValue = cycLoad(TRAS_REF);
            end
            REFRAS: begin
                if (timerDone) begin
                    enterPre = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        if (enterPre) begin
            stateNext  = PRE;
            nRasNext   = 1'b1;
            nCasNext   = 1'b1;
            raSelNext  = 1'b0;
            readyNext  = 1'b0;
            timerLoad  = 1'b1;
            timerValue = cycLoad(TRP);
        end
    end

    // State and output registers; reset drops the strobes immediately without precharge
    always_ff @(posedge FCLK or negedge nRESET) begin
        if (!nRESET) begin
            stateReg <= IDLE;
            nRAS     <= 1'b1;
            nCAS     <= 1'b1;
            RASel    <= 1'b0;
            RAMReady <= 1'b0;
            RefAck   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            nRAS     <= nRasNext;
            nCAS     <= nCasNext;
            RASel    <= raSelNext;
            RAMReady <= readyNext;
            RefAck   <= refAckNext;
        end
    end

endmodule

// File: tb/tb_ram_sequencer.sv
// Directed bench for ram_sequencer: table-driven cycle vectors plus
// hand-written sequences for urgent collision, CAS abort and async reset.
// Output vectors are {nRAS, nCAS, RASel, RAMReady, RefAck};
// input vectors are {ASActive, ASInactive, RAMCS, RefReq, RefUrgent}.
module tb_ram_sequencer;

    logic FCLK       = 1'b0;
    logic nRESET     = 1'b1;
    logic ASActive   = 1'b0;
    logic ASInactive = 1'b0;
    logic RAMCS      = 1'b0;
    logic RefReq     = 1'b0;
    logic RefUrgent  = 1'b0;

    logic RefAck, RAMReady, nRAS, nCAS, RASel;
    logic RefAck3, RAMReady3, nRAS3, nCAS3, RASel3;

    int total = 0;
    int bad   = 0;

    localparam logic [4:0] I_NONE = 5'b00000;
    localparam logic [4:0] I_AS   = 5'b10100;
    localparam logic [4:0] I_ASI  = 5'b01000;
    localparam logic [4:0] I_RR   = 5'b00010;
    localparam logic [4:0] I_ASRR = 5'b10110;
    localparam logic [4:0] I_ASIR = 5'b01010;

    localparam logic [4:0] O_IDLE = 5'b11000;  // also PRE
    localparam logic [4:0] O_ROW  = 5'b01000;
    localparam logic [4:0] O_COL  = 5'b00100;
    localparam logic [4:0] O_HOLD = 5'b00110;
    localparam logic [4:0] O_RCAS = 5'b10000;
    localparam logic [4:0] O_RACK = 5'b00001;
    localparam logic [4:0] O_RRAS = 5'b00000;

    typedef struct {
        string      name;
        logic [4:0] inp;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];

    ram_sequencer dut (
        .FCLK       (FCLK),
        .nRESET     (nRESET),
        .ASActive   (ASActive),
        .ASInactive (ASInactive),
        .RAMCS      (RAMCS),
        .RefReq     (RefReq),
        .RefUrgent  (RefUrgent),
        .RefAck     (RefAck),
        .RAMReady   (RAMReady),
        .nRAS       (nRAS),
        .nCAS       (nCAS),
        .RASel      (RASel)
    );

    ram_sequencer #(.TCAS(3)) dut3 (
        .FCLK       (FCLK),
        .nRESET     (nRESET),
        .ASActive   (ASActive),
        .ASInactive (ASInactive),
        .RAMCS      (RAMCS),
        .RefReq     (RefReq),
        .RefUrgent  (RefUrgent),
        .RefAck     (RefAck3),
        .RAMReady   (RAMReady3),
        .nRAS       (nRAS3),
        .nCAS       (nCAS3),
        .RASel      (RASel3)
    );

    always #5 FCLK = ~FCLK;

    function automatic logic [4:0] outsMain();
        return {nRAS, nCAS, RASel, RAMReady, RefAck};
    endfunction

    function automatic logic [4:0] outs3();
        return {nRAS3, nCAS3, RASel3, RAMReady3, RefAck3};
    endfunction

    task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end else begin
            $display("ok   %s: %b", name, got);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end else begin
            $display("ok   %s: %0d", name, got);
        end
    endtask

    // Apply inputs at the falling edge, sample 1 time unit after the rising edge
    task automatic drive(input logic [4:0] inp);
        @(negedge FCLK);
        {ASActive, ASInactive, RAMCS, RefReq, RefUrgent} = inp;
        @(posedge FCLK);
        #1;
    endtask

    task automatic addVec(input string name, input logic [4:0] inp, input logic [4:0] exp);
        vec_t v;
        v.name = name;
        v.inp  = inp;
        v.exp  = exp;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int readyEdge;
        int ackCount;
        int expEdge;
        logic [4:0] inp;

        // CPU read with defaults, then a back-to-back access proving IDLE after 2 PRE cycles
        addVec("cpu row",      I_AS,   O_ROW);
        addVec("cpu col",      I_AS,   O_COL);
        addVec("cpu ready",    I_AS,   O_HOLD);
        addVec("cpu hold1",    I_AS,   O_HOLD);
        addVec("cpu hold2",    I_AS,   O_HOLD);
        addVec("cpu hold3",    I_AS,   O_HOLD);
        addVec("cpu pre1",     I_ASI,  O_IDLE);
        addVec("cpu pre2",     I_NONE, O_IDLE);
        addVec("cpu pre-end",  I_AS,   O_IDLE);
        addVec("cpu2 row",     I_AS,   O_ROW);
        addVec("cpu2 col",     I_AS,   O_COL);
        addVec("cpu2 ready",   I_AS,   O_HOLD);
        addVec("cpu2 pre1",    I_ASI,  O_IDLE);
        addVec("cpu2 pre2",    I_NONE, O_IDLE);
        addVec("cpu2 idle",    I_NONE, O_IDLE);
        // Idle refresh: CAS first, one RefAck, RAS low 3 cycles, 2 precharge
        addVec("ref cas",      I_RR,   O_RCAS);
        addVec("ref ack",      I_RR,   O_RACK);
        addVec("ref ras2",     I_NONE, O_RRAS);
        addVec("ref ras3",     I_NONE, O_RRAS);
        addVec("ref pre1",     I_NONE, O_IDLE);
        addVec("ref pre2",     I_NONE, O_IDLE);
        addVec("ref pre-end",  I_RR,   O_IDLE);
        addVec("ref2 cas",     I_RR,   O_RCAS);
        addVec("ref2 ack",     I_NONE, O_RACK);
        addVec("ref2 ras2",    I_NONE, O_RRAS);
        addVec("ref2 ras3",    I_NONE, O_RRAS);
        addVec("ref2 pre1",    I_NONE, O_IDLE);
        addVec("ref2 pre2",    I_NONE, O_IDLE);
        addVec("ref2 idle",    I_NONE, O_IDLE);
        // Non-urgent collision: CPU first, refresh right after PRE
        addVec("coll row",     I_ASRR, O_ROW);
        addVec("coll col",     I_ASRR, O_COL);
        addVec("coll ready",   I_ASRR, O_HOLD);
        addVec("coll pre1",    I_ASIR, O_IDLE);
        addVec("coll pre2",    I_RR,   O_IDLE);
        addVec("coll pre-end", I_RR,   O_IDLE);
        addVec("coll refcas",  I_RR,   O_RCAS);
        addVec("coll refack",  I_RR,   O_RACK);
        addVec("coll ras2",    I_NONE, O_RRAS);
        addVec("coll ras3",    I_NONE, O_RRAS);
        addVec("coll pre3",    I_NONE, O_IDLE);
        addVec("coll pre4",    I_NONE, O_IDLE);
        addVec("coll idle",    I_NONE, O_IDLE);

        // Reset: outputs take reset values without a clock edge
        #1 nRESET = 1'b0;
        #1;
        check("reset async", outsMain(), O_IDLE);
        repeat (2) @(posedge FCLK);
        @(negedge FCLK);
        nRESET = 1'b1;
        drive(I_NONE);
        check("reset idle", outsMain(), O_IDLE);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].inp);
            check(vecs[i].name, outsMain(), vecs[i].exp);
        end

        // Urgent collision: CPU request, RefReq and RefUrgent together
`ifdef RAMSEQ_URGENT_PREEMPT_EN
        expEdge = 9;  // refresh 0..5, IDLE sampled at 7, RAMReady after 9
`else
        expEdge = 2;  // urgency ignored: CPU access as usual
`endif
        readyEdge = -1;
        ackCount  = 0;
        inp       = 5'b10111;
        for (int e = 0; e < 20 && readyEdge < 0; e++) begin
            drive(inp);
            if (RefAck) begin
                ackCount++;
                inp[1:0] = 2'b00;
            end
            if (RAMReady) readyEdge = e;
        end
        checkInt("urgent ready edge", readyEdge, expEdge);
        inp = {1'b0, 1'b1, 1'b0, inp[1:0]};
        for (int e = 0; e < 15; e++) begin
            drive(inp);
            inp[3] = 1'b0;
            if (RefAck) begin
                ackCount++;
                inp[1:0] = 2'b00;
            end
        end
        checkInt("urgent refack count", ackCount, 1);
        check("urgent idle", outsMain(), O_IDLE);

        // TCAS=3: full read, RAMReady after the third COL cycle
        drive(I_AS);   check("t3 row",   outs3(), O_ROW);
        drive(I_AS);   check("t3 col1",  outs3(), O_COL);
        drive(I_AS);   check("t3 col2",  outs3(), O_COL);
        drive(I_AS);   check("t3 col3",  outs3(), O_COL);
        drive(I_AS);   check("t3 ready", outs3(), O_HOLD);
        drive(I_ASI);  check("t3 pre",   outs3(), O_IDLE);
        repeat (3) drive(I_NONE);

        // TCAS=3 abort during COL: PRE entered, RAMReady never rises
        drive(I_AS);   check("abort row",  outs3(), O_ROW);
        drive(I_AS);   check("abort col1", outs3(), O_COL);
        drive(I_AS);   check("abort col2", outs3(), O_COL);
        drive(I_ASI);  check("abort pre",  outs3(), O_IDLE);
        for (int e = 0; e < 4; e++) begin
            drive(I_NONE);
            check($sformatf("abort after%0d", e), outs3(), O_IDLE);
        end
        drive(I_AS);   check("abort next row", outs3(), O_ROW);
        drive(I_ASI);
        repeat (3) drive(I_NONE);

        // Reset in HOLD: strobes high and RAMReady low with no clock edge
        drive(I_AS);
        drive(I_AS);
        drive(I_AS);   check("rst hold", outsMain(), O_HOLD);
        #2;
        nRESET = 1'b0;
        {ASActive, ASInactive, RAMCS, RefReq, RefUrgent} = I_NONE;
        #1;
        check("rst mid-hold", outsMain(), O_IDLE);
        @(negedge FCLK);
        nRESET = 1'b1;
        drive(I_NONE); check("rst after", outsMain(), O_IDLE);
        drive(I_AS);   check("rst then row", outsMain(), O_ROW);
        drive(I_AS);
        drive(I_AS);   check("rst then ready", outsMain(), O_HOLD);
        drive(I_ASI);
        repeat (3) drive(I_NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_sequencer.md
# ram_sequencer

Sequences the DRAM array behind the FSB: arbitrates between CPU accesses and the refresh requests raised by the FSB refresh counter, and drives RAS/CAS, the row/column address select, the RAM `Ready` term and `RefAck`. It sits between the FSB block (consumes `ASActive`, `ASInactive`, `RefReq`, `RefUrgent`; returns `RefAck` and `RAMReady`) and the DRAM pins. All state advances on `posedge FCLK`.

## Interface
Parameters:
- `TCAS`, 1: cycles `nCAS` is low before `RAMReady` asserts (legal 1..7)
- `TRP`, 2: precharge cycles with `nRAS`/`nCAS` high (legal 1..7)
- `TRAS_REF`, 3: cycles `nRAS` is low during a refresh (legal 1..7)

Ports:
- `FCLK` in 1: FSB clock; the only clock
- `nRESET` in 1: reset, asynchronous, active-low
- `ASActive` in 1: CPU address strobe active (from FSB)
- `ASInactive` in 1: strobe released, filtered (from FSB)
- `RAMCS` in 1: address decode hit on RAM, valid while `ASActive`
- `RefReq` in 1: refresh pending
- `RefUrgent` in 1: refresh overdue
- `RefAck` out 1: one-cycle pulse, refresh performed
- `RAMReady` out 1: RAM access complete; ORed into FSB `Ready` elsewhere
- `nRAS` out 1: DRAM row strobe
- `nCAS` out 1: DRAM column strobe
- `RASel` out 1: 0 selects row address, 1 selects column address

## Operation
- All outputs are registered. Reset values: `nRAS`=1, `nCAS`=1, `RASel`=0, `RAMReady`=0, `RefAck`=0, state IDLE, cycle counter 0. Reset applied mid-access returns everything to these values immediately, with no precharge.
- States: IDLE, ROW, COL, HOLD, PRE, REFCAS, REFRAS.
- IDLE, priority top-down:
  - `RefUrgent` -> REFCAS (only with the macro; see Configuration)
  - `ASActive && RAMCS` -> ROW
  - `RefReq` -> REFCAS
  - otherwise stay in IDLE
- ROW: `nRAS`=0, `RASel`=0. Lasts 1 cycle, then COL.
- COL: `RASel`=1, `nCAS`=0. Lasts `TCAS` cycles. On exit, `RAMReady`=1 and the block enters HOLD.
- HOLD: `nRAS`, `nCAS` and `RAMReady` hold their values until `ASInactive`, then PRE.
- `ASInactive` in ROW or COL aborts the access: go to PRE, `RAMReady` never asserts.
- PRE: `nRAS`=1, `nCAS`=1, `RAMReady`=0, `RASel`=0. Lasts `TRP` cycles, then IDLE.
- REFCAS (CAS-before-RAS refresh): `nCAS`=0, `nRAS`=1. Lasts 1 cycle, then REFRAS.
- REFRAS: `nRAS`=0, `nCAS`=0 for `TRAS_REF` cycles, then PRE. `RefAck`=1 during the first REFRAS cycle only.
- A refresh, once started, always completes. A CPU strobe arriving during a refresh waits in IDLE after PRE; the FSB stalls because `RAMReady`=0.
- Cycle counter: 3 bits, loaded with (parameter − 1) on state entry and decremented to 0. No wrap: the counter saturates at 0.

## Timing
- CPU access: `ASActive && RAMCS` sampled in IDLE at edge N.
  - `nRAS` low after N
  - `nCAS` low and `RASel`=1 after N+1
  - `RAMReady` high after N+1+`TCAS`; with defaults, after N+2
- `ASInactive` sampled at edge M in HOLD: `nRAS`, `nCAS` high and `RAMReady` low after M; IDLE re-entered after M+`TRP`.
- Refresh from IDLE at edge N:
  - `nCAS` low after N
  - `nRAS` low and `RefAck` high after N+1
  - `RefAck` low after N+2
  - PRE entered after N+1+`TRAS_REF`
- Simultaneous `ASActive&&RAMCS` and `RefReq` (not urgent) in IDLE: the CPU wins.
- `RefReq` is expected to drop within the cycle after `RefAck` is sampled. A `RefReq` still high in IDLE triggers another refresh, which is legal.

## Configuration
- `RAMSEQ_URGENT_PREEMPT_EN` defined: `RefUrgent` in IDLE beats a simultaneous CPU request.
- Undefined: `RefUrgent` is ignored and the CPU always wins arbitration in IDLE. Refresh occurs only in IDLE cycles with no CPU request.

## Structure
- Shared package `ram_pkg`:
  - state enum typedef
  - counter width constant (3)
  - default `TCAS`/`TRP`/`TRAS_REF` values
- One sub-module, `ram_cyc_timer`: a loadable 3-bit down-counter with a `done` flag, used for the COL, REFRAS and PRE durations.

## Test plan
- CPU read, defaults: `RAMCS`+`ASActive` at edge 0 -> `nRAS` low at 1, `nCAS` low at 2, `RAMReady` high at 3; `ASInactive` at 6 -> strobes high at 7, IDLE at 9.
- Idle refresh: `RefReq` with no AS -> `nCAS` low 1 cycle before `nRAS`, exactly one `RefAck` cycle, `nRAS` low 3 cycles, then 2 precharge cycles.
- Collision, `RefReq`=1, `RefUrgent`=0, with CPU request -> CPU access first, refresh immediately after PRE.
- Collision with `RefUrgent`=1 -> macro on: refresh first, `RAMReady` delayed to edge 9; macro off: CPU first.
- Abort: `ASInactive` during COL with `TCAS`=3 -> `RAMReady` stays 0, PRE entered.
- Reset mid-HOLD: `nRESET` low -> `nRAS`=`nCAS`=1 and `RAMReady`=0 without a clock edge; after release, IDLE.
